// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one full-subtractor cell and a borrow FF, LSB first
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Diff
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH:0] diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bw_q, bw_d, d, bw_n, load;
  // operands shift right so the cell always sees the current bit at position 0
  assign d    = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  assign load = start && (state_q != RUN);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    if (load) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      bw_d    = Bin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {d, res_q[WIDTH-1:1]};
      bw_d  = bw_n;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        diff_d  = {bw_n, d, res_q[WIDTH-1:1]};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Diff = diff_q;
endmodule
